// File: rtl/mem_bus_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the memory/peripheral bus controller:
//   - default parameter values (widths, slave count, timeout)
//   - FSM state encodings and the state enum built on them
//   - fill value used for read data on error and write responses
// -----------------------------------------------------------------------------
package bus_pkg;

    // Default parameter values
    localparam int DEF_ADDR_W   = 32;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_N_SLAVES = 4;
    localparam int DEF_SEL_LSB  = 8;
    localparam int DEF_SEL_W    = 2;
    localparam int DEF_TIMEOUT  = 15;

    // FSM state encodings
    localparam logic [1:0] STATE_IDLE   = 2'd0;
    localparam logic [1:0] STATE_ACCESS = 2'd1;
    localparam logic [1:0] STATE_RESP   = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE   = STATE_IDLE,
        S_ACCESS = STATE_ACCESS,
        S_RESP   = STATE_RESP
    } state_e;

    // Read data returned on decode error, timeout and write completion.
    // Replicated to DATA_W at the point of use.
    localparam logic ERR_RDATA_FILL = 1'b0;

endpackage : bus_pkg

// File: rtl/mem_bus_ctrl_if.sv
// -----------------------------------------------------------------------------
// mem_bus_ctrl_if
// Groups the core-side request/response handshake and the shared slave bus.
//   Core side : req_valid, req_ready, req_we, req_addr, req_wdata,
//               rsp_valid, rsp_rdata, rsp_err
//   Slave side: s_valid (one-hot), s_we, s_addr, s_wdata, s_ready, s_rdata
// Modports:
//   slave  - the controller: accepts core requests, drives the slave bus
//   master - the environment: the core plus the slave devices
// -----------------------------------------------------------------------------
interface mem_bus_ctrl_if
    import bus_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int N_SLAVES = DEF_N_SLAVES,
    parameter int SEL_LSB  = DEF_SEL_LSB
) ();

    // Core request / response
    logic                         req_valid;
    logic                         req_ready;
    logic                         req_we;
    logic [ADDR_W-1:0]            req_addr;
    logic [DATA_W-1:0]            req_wdata;
    logic                         rsp_valid;
    logic [DATA_W-1:0]            rsp_rdata;
    logic                         rsp_err;

    // Slave bus
    logic [N_SLAVES-1:0]          s_valid;
    logic                         s_we;
    logic [SEL_LSB-1:0]           s_addr;
    logic [DATA_W-1:0]            s_wdata;
    logic [N_SLAVES-1:0]          s_ready;
    logic [N_SLAVES*DATA_W-1:0]   s_rdata;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, s_ready, s_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               s_valid, s_we, s_addr, s_wdata
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, s_ready, s_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               s_valid, s_we, s_addr, s_wdata
    );

endinterface : mem_bus_ctrl_if

// File: rtl/mem_bus_ctrl_addr_decode.sv
// -----------------------------------------------------------------------------
// bus_addr_decode
// Combinational region decoder. The slave-select field is
// i_addr[SEL_LSB +: SEL_W]; indices at or above N_SLAVES are unmapped.
// Ports:
//   i_addr        in  ADDR_W    request byte address
//   o_idx         out SEL_W     raw slave index from the select field
//   o_sel         out N_SLAVES  one-hot select, all-zero when unmapped
//   o_decode_err  out 1         index does not name an existing slave
// -----------------------------------------------------------------------------
module bus_addr_decode
    import bus_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int N_SLAVES = DEF_N_SLAVES,
    parameter int SEL_LSB  = DEF_SEL_LSB,
    parameter int SEL_W    = DEF_SEL_W
) (
    input  logic [ADDR_W-1:0]   i_addr,
    output logic [SEL_W-1:0]    o_idx,
    output logic [N_SLAVES-1:0] o_sel,
    output logic                o_decode_err
);

    always_comb begin
        // NOTE: every output gets a value before any conditional logic so
        // no path leaves one unassigned, which would infer a latch.
        o_idx        = i_addr[SEL_LSB +: SEL_W];
        o_sel        = '0;
        o_decode_err = (int'(o_idx) >= N_SLAVES);
        for (int k = 0; k < N_SLAVES; k++) begin
            o_sel[k] = (int'(o_idx) == k);
        end
    end

endmodule : bus_addr_decode

// File: rtl/mem_bus_ctrl.sv
// -----------------------------------------------------------------------------
// mem_bus_ctrl
// Bus controller between the core load/store port and N memory-mapped
// slaves. One outstanding transaction; the core stalls on req_ready.
// Unmapped addresses and slaves that stay silent for TIMEOUT cycles
// complete with rsp_err. All outputs are registered except req_ready,
// which is decoded from the state register.
// Ports:
//   clk    in  1   clock, all state on the rising edge
//   rst_n  in  1   synchronous active-low reset
//   bus    slave modport of mem_bus_ctrl_if (core request/response and
//                  shared slave bus)
// -----------------------------------------------------------------------------
module mem_bus_ctrl
    import bus_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int N_SLAVES = DEF_N_SLAVES,
    parameter int SEL_LSB  = DEF_SEL_LSB,
    parameter int SEL_W    = DEF_SEL_W,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_bus_ctrl_if.slave bus
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [DATA_W-1:0] ERR_RDATA = {DATA_W{ERR_RDATA_FILL}};

    // State and registered outputs
    state_e              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [SEL_W-1:0]    r_idx;
    logic [N_SLAVES-1:0] r_s_valid;
    logic                r_s_we;
    logic [SEL_LSB-1:0]  r_s_addr;
    logic [DATA_W-1:0]   r_s_wdata;
    logic                r_rsp_valid;
    logic                r_rsp_err;
    logic [DATA_W-1:0]   r_rsp_rdata;

    // Next-state values
    state_e              w_state_d;
    logic [CNT_W-1:0]    w_cnt_d;
    logic [N_SLAVES-1:0] w_s_valid_d;
    logic                w_rsp_valid_d;
    logic                w_rsp_err_d;
    logic [DATA_W-1:0]   w_rsp_rdata_d;
    logic                w_accept;

    // Decoder outputs and selected-slave views
    logic [SEL_W-1:0]    w_idx;
    logic [N_SLAVES-1:0] w_sel;
    logic                w_decode_err;
    logic                w_ready_hit;
    logic [DATA_W-1:0]   w_rdata_sel;

    bus_addr_decode #(
        .ADDR_W   (ADDR_W),
        .N_SLAVES (N_SLAVES),
        .SEL_LSB  (SEL_LSB),
        .SEL_W    (SEL_W)
    ) u_decode (
        .i_addr       (bus.req_addr),
        .o_idx        (w_idx),
        .o_sel        (w_sel),
        .o_decode_err (w_decode_err)
    );

    // r_s_valid is the one-hot strobe of the slave being accessed, so
    // masking s_ready with it ignores every other channel.
    assign w_ready_hit = |(bus.s_ready & r_s_valid);

    always_comb begin
        w_rdata_sel = '0;
        for (int k = 0; k < N_SLAVES; k++) begin
            if (int'(r_idx) == k) begin
                w_rdata_sel = bus.s_rdata[k*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state and next-output logic. Registered outputs take the value
    // they must show in the state being entered.
    always_comb begin
        w_state_d     = r_state;
        w_cnt_d       = r_cnt;
        w_s_valid_d   = '0;
        w_rsp_valid_d = 1'b0;
        w_rsp_err_d   = 1'b0;
        w_rsp_rdata_d = '0;
        w_accept      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    w_accept = 1'b1;
                    if (w_decode_err) begin
                        w_state_d     = S_RESP;
                        w_rsp_valid_d = 1'b1;
                        w_rsp_err_d   = 1'b1;
                        w_rsp_rdata_d = ERR_RDATA;
                    end else begin
                        w_state_d   = S_ACCESS;
                        w_cnt_d     = '0;
                        w_s_valid_d = w_sel;
                    end
                end
            end

            S_ACCESS: begin
                // Ready is checked before the timeout so a response in the
                // last allowed cycle still completes cleanly.
                if (w_ready_hit) begin
                    w_state_d     = S_RESP;
                    w_rsp_valid_d = 1'b1;
                    w_rsp_rdata_d = r_s_we ? ERR_RDATA : w_rdata_sel;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_d     = S_RESP;
                    w_rsp_valid_d = 1'b1;
                    w_rsp_err_d   = 1'b1;
                    w_rsp_rdata_d = ERR_RDATA;
                end else begin
                    w_cnt_d     = r_cnt + CNT_W'(1);
                    w_s_valid_d = r_s_valid;
                end
            end

            S_RESP: begin
                w_state_d = S_IDLE;
            end

            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_s_valid   <= '0;
            r_s_we      <= 1'b0;
            r_s_addr    <= '0;
            r_s_wdata   <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_state     <= w_state_d;
            r_cnt       <= w_cnt_d;
            r_s_valid   <= w_s_valid_d;
            r_rsp_valid <= w_rsp_valid_d;
            r_rsp_err   <= w_rsp_err_d;
            r_rsp_rdata <= w_rsp_rdata_d;
            if (w_accept) begin
                r_idx     <= w_idx;
                r_s_we    <= bus.req_we;
                r_s_addr  <= bus.req_addr[SEL_LSB-1:0];
                r_s_wdata <= bus.req_wdata;
            end
        end
    end

    assign bus.req_ready = (r_state == S_IDLE);
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.s_valid   = r_s_valid;
    assign bus.s_we      = r_s_we;
    assign bus.s_addr    = r_s_addr;
    assign bus.s_wdata   = r_s_wdata;

endmodule : mem_bus_ctrl

// File: tb/tb_mem_bus_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_ctrl
// Directed bench for mem_bus_ctrl. Two instances share clock and reset:
//   u_dut4 - 4 slaves, TIMEOUT 15 (main traffic)
//   u_dut3 - 3 slaves (unmapped region at index 3)
// Inputs change and outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_mem_bus_ctrl;
    import bus_pkg::*;

    logic clk;
    logic rst_n;

    int n_pass  = 0;
    int n_total = 0;

    mem_bus_ctrl_if #(.N_SLAVES(4)) bus4 ();
    mem_bus_ctrl_if #(.N_SLAVES(3)) bus3 ();

    mem_bus_ctrl #(.N_SLAVES(4), .TIMEOUT(15)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4.slave)
    );

    mem_bus_ctrl #(.N_SLAVES(3), .TIMEOUT(15)) u_dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic core_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        bus4.req_valid = 1'b1;
        bus4.req_we    = we;
        bus4.req_addr  = addr;
        bus4.req_wdata = wdata;
    endtask

    initial begin
        rst_n = 1'b0;
        bus4.req_valid = 1'b0; bus4.req_we = 1'b0; bus4.req_addr = '0; bus4.req_wdata = '0;
        bus4.s_ready = '0; bus4.s_rdata = '0;
        bus3.req_valid = 1'b0; bus3.req_we = 1'b0; bus3.req_addr = '0; bus3.req_wdata = '0;
        bus3.s_ready = '0; bus3.s_rdata = '0;

        tick();
        tick();

        // ---- Reset state ----
        check("rst_req_ready", 64'(bus4.req_ready), 64'(1));
        check("rst_rsp_valid", 64'(bus4.rsp_valid), 64'(0));
        check("rst_rsp_rdata", 64'(bus4.rsp_rdata), 64'(0));
        check("rst_rsp_err",   64'(bus4.rsp_err),   64'(0));
        check("rst_s_valid",   64'(bus4.s_valid),   64'(0));
        check("rst_s_we",      64'(bus4.s_we),      64'(0));
        check("rst_s_addr",    64'(bus4.s_addr),    64'(0));
        check("rst_s_wdata",   64'(bus4.s_wdata),   64'(0));
        rst_n = 1'b1;
        tick();

        // ---- Read slave 1 at 0x104, ready on first access cycle ----
        core_req(1'b0, 32'h0000_0104, 32'h0);
        check("rd1_ready_T", 64'(bus4.req_ready), 64'(1));
        tick();                                    // T+1
        bus4.req_valid = 1'b0;
        check("rd1_s_valid", 64'(bus4.s_valid),   64'(4'b0010));
        check("rd1_s_addr",  64'(bus4.s_addr),    64'(8'h04));
        check("rd1_s_we",    64'(bus4.s_we),      64'(0));
        check("rd1_busy",    64'(bus4.req_ready), 64'(0));
        check("rd1_no_rsp",  64'(bus4.rsp_valid), 64'(0));
        bus4.s_ready = 4'b0010;
        bus4.s_rdata[1*32 +: 32] = 32'hDEAD_BEEF;
        tick();                                    // T+2
        bus4.s_ready = '0;
        check("rd1_rsp_valid", 64'(bus4.rsp_valid), 64'(1));
        check("rd1_rsp_rdata", 64'(bus4.rsp_rdata), 64'(32'hDEAD_BEEF));
        check("rd1_rsp_err",   64'(bus4.rsp_err),   64'(0));
        check("rd1_s_drop",    64'(bus4.s_valid),   64'(0));
        check("rd1_resp_busy", 64'(bus4.req_ready), 64'(0));
        tick();                                    // T+3
        check("rd1_rsp_pulse", 64'(bus4.rsp_valid), 64'(0));
        check("rd1_ready_T3",  64'(bus4.req_ready), 64'(1));

        // ---- Write 0x1234_5678 to slave 0 offset 0x10, three wait cycles ----
        bus4.s_rdata = {4{32'hA5A5_5A5A}};
        core_req(1'b1, 32'h0000_0010, 32'h1234_5678);
        tick();                                    // T+1
        bus4.req_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            check("wr_s_valid", 64'(bus4.s_valid),   64'(4'b0001));
            check("wr_s_we",    64'(bus4.s_we),      64'(1));
            check("wr_s_wdata", 64'(bus4.s_wdata),   64'(32'h1234_5678));
            check("wr_s_addr",  64'(bus4.s_addr),    64'(8'h10));
            check("wr_no_rsp",  64'(bus4.rsp_valid), 64'(0));
            if (i == 4) bus4.s_ready = 4'b0001;
            tick();
        end                                        // T+5
        bus4.s_ready = '0;
        check("wr_rsp_valid", 64'(bus4.rsp_valid), 64'(1));
        check("wr_rsp_rdata", 64'(bus4.rsp_rdata), 64'(0));
        check("wr_rsp_err",   64'(bus4.rsp_err),   64'(0));
        tick();

        // ---- Decode error on the 3-slave instance, addr 0x300 ----
        bus3.s_ready = 3'b111;                     // must be ignored
        bus3.req_valid = 1'b1;
        bus3.req_we    = 1'b0;
        bus3.req_addr  = 32'h0000_0300;
        check("dec_ready_T", 64'(bus3.req_ready), 64'(1));
        tick();                                    // T+1
        bus3.req_valid = 1'b0;
        check("dec_s_valid",   64'(bus3.s_valid),   64'(0));
        check("dec_rsp_valid", 64'(bus3.rsp_valid), 64'(1));
        check("dec_rsp_err",   64'(bus3.rsp_err),   64'(1));
        check("dec_rsp_rdata", 64'(bus3.rsp_rdata), 64'(0));
        check("dec_busy",      64'(bus3.req_ready), 64'(0));
        tick();                                    // T+2
        bus3.s_ready = '0;
        check("dec_ready_T2",  64'(bus3.req_ready), 64'(1));
        check("dec_rsp_pulse", 64'(bus3.rsp_valid), 64'(0));

        // ---- Timeout: slave 2 never ready ----
        bus4.s_rdata[2*32 +: 32] = 32'h7777_7777;
        core_req(1'b0, 32'h0000_0204, 32'h0);
        tick();                                    // T+1
        bus4.req_valid = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            check("to_s_valid", 64'(bus4.s_valid),   64'(4'b0100));
            check("to_no_rsp",  64'(bus4.rsp_valid), 64'(0));
            tick();
        end                                        // T+16
        check("to_rsp_valid", 64'(bus4.rsp_valid), 64'(1));
        check("to_rsp_err",   64'(bus4.rsp_err),   64'(1));
        check("to_rsp_rdata", 64'(bus4.rsp_rdata), 64'(0));
        check("to_s_drop",    64'(bus4.s_valid),   64'(0));
        tick();
        check("to_ready_after", 64'(bus4.req_ready), 64'(1));

        // ---- Ready in the final timeout cycle wins ----
        core_req(1'b0, 32'h0000_0208, 32'h0);
        tick();                                    // T+1
        bus4.req_valid = 1'b0;
        for (int i = 1; i <= 14; i++) tick();      // T+15
        check("tol_s_valid_15", 64'(bus4.s_valid), 64'(4'b0100));
        bus4.s_ready = 4'b0100;
        bus4.s_rdata[2*32 +: 32] = 32'hCAFE_F00D;
        tick();                                    // T+16
        bus4.s_ready = '0;
        check("tol_rsp_valid", 64'(bus4.rsp_valid), 64'(1));
        check("tol_rsp_err",   64'(bus4.rsp_err),   64'(0));
        check("tol_rsp_rdata", 64'(bus4.rsp_rdata), 64'(32'hCAFE_F00D));
        tick();

        // ---- Reset during ACCESS ----
        core_req(1'b0, 32'h0000_0304, 32'h0);
        tick();                                    // T+1
        bus4.req_valid = 1'b0;
        check("rst_mid_s_valid", 64'(bus4.s_valid), 64'(4'b1000));
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst_mid_s_drop", 64'(bus4.s_valid),   64'(0));
        check("rst_mid_ready",  64'(bus4.req_ready), 64'(1));
        check("rst_mid_no_rsp", 64'(bus4.rsp_valid), 64'(0));
        bus4.s_ready = 4'b1000;                    // late ready from the dropped access
        tick();
        bus4.s_ready = '0;
        check("rst_mid_no_rsp2", 64'(bus4.rsp_valid), 64'(0));
        check("rst_mid_idle",    64'(bus4.req_ready), 64'(1));
        // following read completes normally
        bus4.s_rdata[3*32 +: 32] = 32'h0BAD_CAFE;
        core_req(1'b0, 32'h0000_0308, 32'h0);
        tick();                                    // T+1
        bus4.req_valid = 1'b0;
        check("post_rst_s_valid", 64'(bus4.s_valid), 64'(4'b1000));
        check("post_rst_s_addr",  64'(bus4.s_addr),  64'(8'h08));
        bus4.s_ready = 4'b1000;
        tick();                                    // T+2
        bus4.s_ready = '0;
        check("post_rst_rsp_valid", 64'(bus4.rsp_valid), 64'(1));
        check("post_rst_rsp_rdata", 64'(bus4.rsp_rdata), 64'(32'h0BAD_CAFE));
        check("post_rst_rsp_err",   64'(bus4.rsp_err),   64'(0));
        tick();

        // ---- Back-to-back reads: slave 2 then slave 3, req_valid held ----
        bus4.s_rdata[2*32 +: 32] = 32'h2222_2222;
        bus4.s_rdata[3*32 +: 32] = 32'h3333_3333;
        bus4.s_rdata[0*32 +: 32] = 32'hFFFF_0000;
        core_req(1'b0, 32'h0000_0200, 32'h0);
        tick();                                    // T+1, first accept done
        bus4.req_addr = 32'h0000_0300;             // next request, valid stays high
        check("b2b_a_s_valid", 64'(bus4.s_valid),   64'(4'b0100));
        check("b2b_a_busy",    64'(bus4.req_ready), 64'(0));
        bus4.s_ready = 4'b0001;                    // stray pulse from slave 0
        tick();                                    // T+2
        check("b2b_stray_s_valid", 64'(bus4.s_valid),   64'(4'b0100));
        check("b2b_stray_no_rsp",  64'(bus4.rsp_valid), 64'(0));
        bus4.s_ready = 4'b0100;
        tick();                                    // T+3
        bus4.s_ready = 4'b0001;                    // stray pulse during RESP
        check("b2b_a_rsp_valid", 64'(bus4.rsp_valid), 64'(1));
        check("b2b_a_rsp_rdata", 64'(bus4.rsp_rdata), 64'(32'h2222_2222));
        check("b2b_a_resp_busy", 64'(bus4.req_ready), 64'(0));
        tick();                                    // T+4, second accept here
        bus4.s_ready = '0;
        check("b2b_b_ready",  64'(bus4.req_ready), 64'(1));
        check("b2b_b_no_sv",  64'(bus4.s_valid),   64'(0));
        tick();                                    // T+5
        bus4.req_valid = 1'b0;
        check("b2b_b_s_valid", 64'(bus4.s_valid),   64'(4'b1000));
        check("b2b_b_s_addr",  64'(bus4.s_addr),    64'(8'h00));
        check("b2b_b_busy",    64'(bus4.req_ready), 64'(0));
        bus4.s_ready = 4'b1001;
        tick();                                    // T+6
        bus4.s_ready = '0;
        check("b2b_b_rsp_valid", 64'(bus4.rsp_valid), 64'(1));
        check("b2b_b_rsp_rdata", 64'(bus4.rsp_rdata), 64'(32'h3333_3333));
        check("b2b_b_rsp_err",   64'(bus4.rsp_err),   64'(0));
        tick();
        check("b2b_end_ready",  64'(bus4.req_ready), 64'(1));
        check("b2b_end_no_rsp", 64'(bus4.rsp_valid), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_mem_bus_ctrl
